pc_fetch_unit: RTL and testbench

//  Upstream of the instruction decoder: holds the PC, fetches from instruction memory/cache with a

---
 rtl/pc_fetch_unit_if.sv | 28 ++
 rtl/pc_fetch_unit.sv | 98 +++++++++
 tb/tb_pc_fetch_unit.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/pc_fetch_unit_if.sv
// Bus between the PC/fetch unit and its neighbours: instruction memory, the decoder/ALU
// control flags, and the registered instruction, PC and retire count.
interface pc_fetch_unit_if #(
  parameter int CNT_WIDTH = 16
);
  logic [31:0]          INSTR_IN;
  logic                 IMEM_BUSYWAIT;
  logic                 IMEM_READ;
  logic                 DATA_BUSYWAIT;
  logic                 BRANCH;
  logic                 B_NOTEQUAL;
  logic                 JUMP;
  logic                 ZERO;
  logic [31:0]          PC;
  logic [31:0]          INSTRUCTION;
  logic                 INSTR_VALID;
  logic [CNT_WIDTH-1:0] RETIRED;

  modport master (
    input  INSTR_IN, IMEM_BUSYWAIT, DATA_BUSYWAIT, BRANCH, B_NOTEQUAL, JUMP, ZERO,
    output IMEM_READ, PC, INSTRUCTION, INSTR_VALID, RETIRED
  );

  modport slave (
    output INSTR_IN, IMEM_BUSYWAIT, DATA_BUSYWAIT, BRANCH, B_NOTEQUAL, JUMP, ZERO,
    input  IMEM_READ, PC, INSTRUCTION, INSTR_VALID, RETIRED
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// PC holder and two-state fetch/execute sequencer: fetches through a busywait handshake,
// presents a registered instruction and resolves the next PC from branch/jump flags.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] BUBBLE    = 32'hFF00_0000,
  parameter int          CNT_WIDTH = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  pc_fetch_unit_if.master  bus
);

  typedef enum logic {
    FETCH = 1'b0,
    EXEC  = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [31:0]          pc_q, pc_d;
  logic [31:0]          instr_q, instr_d;
  logic                 valid_q, valid_d;
  logic                 read_q, read_d;
  logic [CNT_WIDTH-1:0] retired_q, retired_d;

  logic [31:0]          offset_s;
  logic                 taken_s;
  logic [31:0]          next_pc_s;

  // Word offset keeps PC[1:0] untouched; the sum wraps modulo 2^32.
  assign offset_s  = {{22{instr_q[23]}}, instr_q[23:16], 2'b00};
  assign taken_s   = bus.JUMP | (bus.BRANCH & bus.ZERO) | (bus.B_NOTEQUAL & ~bus.ZERO);
  assign next_pc_s = pc_q + 32'd4 + (taken_s ? offset_s : 32'd0);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q   <= FETCH;
      pc_q      <= RESET_PC;
      instr_q   <= BUBBLE;
      valid_q   <= 1'b0;
      read_q    <= 1'b1;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      valid_q   <= valid_d;
      read_q    <= read_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    valid_d   = valid_q;
    read_d    = read_q;
    retired_d = retired_q;
    case (state_q)
      FETCH: begin
        if (!bus.IMEM_BUSYWAIT) begin
          instr_d = bus.INSTR_IN;
          valid_d = 1'b1;
          read_d  = 1'b0;
          state_d = EXEC;
        end else begin
          state_d = FETCH;
        end
      end
      EXEC: begin
        // Control flags are only meaningful here, once decoder and ALU have settled.
        if (!bus.DATA_BUSYWAIT) begin
          pc_d      = next_pc_s;
          retired_d = retired_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
          instr_d   = BUBBLE;
          valid_d   = 1'b0;
          read_d    = 1'b1;
          state_d   = FETCH;
        end else begin
          state_d = EXEC;
        end
      end
      default: begin
        state_d = FETCH;
        instr_d = BUBBLE;
        valid_d = 1'b0;
        read_d  = 1'b1;
      end
    endcase
  end

  assign bus.PC          = pc_q;
  assign bus.INSTRUCTION = instr_q;
  assign bus.INSTR_VALID = valid_q;
  assign bus.IMEM_READ   = read_q;
  assign bus.RETIRED     = retired_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Table-driven bench for pc_fetch_unit with a scoreboard of expected PC/retire count
// after each instruction, plus hand-written reset and wrap-around sequences.
module tb_pc_fetch_unit;

  localparam logic [31:0] BUBBLE = 32'hFF00_0000;
  localparam logic [31:0] NOP    = 32'h0000_0001;
  localparam int          CW     = 8;

  typedef struct {
    logic [31:0] instr;
    int          iw;
    int          dw;
    logic        br;
    logic        bne;
    logic        j;
    logic        z;
    logic [31:0] exp_pc;
  } vec_t;

  typedef struct {
    logic [31:0]   pc;
    logic [CW-1:0] ret;
  } exp_t;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  logic [31:0]   model_pc;
  logic [CW-1:0] exp_ret;
  exp_t          sb[$];
  vec_t          tbl[14];

  pc_fetch_unit_if #(.CNT_WIDTH(CW)) bus();

  pc_fetch_unit #(.CNT_WIDTH(CW)) dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_instr(input vec_t v);
    int   cyc;
    exp_t e;
    cyc = 0;
    check("fetch_pc", bus.PC, model_pc);
    check("fetch_valid", bus.INSTR_VALID, 1'b0);
    check("fetch_read", bus.IMEM_READ, 1'b1);
    check("fetch_bubble", bus.INSTRUCTION, BUBBLE);
    // flags and data busywait must be ignored during fetch
    bus.DATA_BUSYWAIT = 1'b1;
    bus.JUMP = 1'b1;
    bus.BRANCH = 1'b1;
    bus.ZERO = 1'b1;
    bus.IMEM_BUSYWAIT = 1'b1;
    for (int k = 0; k < v.iw; k++) begin
      tick();
      cyc++;
      check("imem_stall_pc", bus.PC, model_pc);
      check("imem_stall_valid", bus.INSTR_VALID, 1'b0);
    end
    bus.IMEM_BUSYWAIT = 1'b0;
    bus.INSTR_IN = v.instr;
    tick();
    cyc++;
    bus.INSTR_IN = $urandom;
    bus.IMEM_BUSYWAIT = 1'b1;
    check("exec_valid", bus.INSTR_VALID, 1'b1);
    check("exec_instr", bus.INSTRUCTION, v.instr);
    check("exec_read", bus.IMEM_READ, 1'b0);
    check("exec_pc", bus.PC, model_pc);
    bus.BRANCH = v.br;
    bus.B_NOTEQUAL = v.bne;
    bus.JUMP = v.j;
    bus.ZERO = v.z;
    if (v.br && v.bne)
      $display("note: illegal BRANCH and B_NOTEQUAL both high at PC %08h", model_pc);
    for (int k = 0; k < v.dw; k++) begin
      tick();
      cyc++;
      check("dmem_stall_pc", bus.PC, model_pc);
      check("dmem_stall_instr", bus.INSTRUCTION, v.instr);
      check("dmem_stall_ret", bus.RETIRED, exp_ret);
    end
    bus.DATA_BUSYWAIT = 1'b0;
    e.pc  = v.exp_pc;
    e.ret = exp_ret + 8'd1;
    sb.push_back(e);
    tick();
    cyc++;
    e = sb.pop_front();
    check("next_pc", bus.PC, e.pc);
    check("retired", bus.RETIRED, e.ret);
    check("retire_valid", bus.INSTR_VALID, 1'b0);
    check("retire_read", bus.IMEM_READ, 1'b1);
    check("cycles", cyc, 2 + v.iw + v.dw);
    model_pc = e.pc;
    exp_ret  = e.ret;
    bus.IMEM_BUSYWAIT = 1'b0;
    bus.BRANCH = 1'b0;
    bus.B_NOTEQUAL = 1'b0;
    bus.JUMP = 1'b0;
    bus.ZERO = 1'b0;
  endtask

  function automatic vec_t nop_to(input logic [31:0] pc);
    vec_t v;
    v = '{NOP, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, pc};
    return v;
  endfunction

  initial begin
    vec_t v;
    n_vec = 0;
    n_err = 0;
    //           instr          iw dw br    bne   j     z     next PC
    tbl[0]  = '{NOP,            0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0004};
    tbl[1]  = '{NOP,            0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0008};
    tbl[2]  = '{NOP,            0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_000C};
    tbl[3]  = '{NOP,            4, 3, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0010};
    tbl[4]  = '{32'h00FE_0000,  0, 0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_000C};
    tbl[5]  = '{NOP,            0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0010};
    tbl[6]  = '{32'h00FE_0000,  0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0014};
    tbl[7]  = '{32'h0002_0000,  1, 0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0020};
    tbl[8]  = '{32'h0003_0000,  0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0030};
    tbl[9]  = '{32'h0073_0000,  0, 2, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0200};
    tbl[10] = '{32'h0080_0000,  0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0004};
    tbl[11] = '{32'h0010_0000,  0, 0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0008};
    tbl[12] = '{32'h0002_0000,  2, 1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0014};
    tbl[13] = '{32'h00FB_0000,  0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0004};

    bus.INSTR_IN = 32'h0;
    bus.IMEM_BUSYWAIT = 1'b0;
    bus.DATA_BUSYWAIT = 1'b0;
    bus.BRANCH = 1'b0;
    bus.B_NOTEQUAL = 1'b0;
    bus.JUMP = 1'b0;
    bus.ZERO = 1'b0;
    rst = 1'b1;
    repeat (2) tick();
    check("rst_pc", bus.PC, 32'h0);
    check("rst_instr", bus.INSTRUCTION, BUBBLE);
    check("rst_valid", bus.INSTR_VALID, 1'b0);
    check("rst_read", bus.IMEM_READ, 1'b1);
    check("rst_ret", bus.RETIRED, 8'd0);
    rst = 1'b0;
    model_pc = 32'h0;
    exp_ret  = 8'd0;

    for (int i = 0; i < 14; i++) run_instr(tbl[i]);

    // Reset while stalled in EXEC: must act immediately, without waiting for an edge.
    bus.INSTR_IN = NOP;
    tick();
    bus.DATA_BUSYWAIT = 1'b1;
    check("pre_rst_valid", bus.INSTR_VALID, 1'b1);
    tick();
    tick();
    rst = 1'b1;
    #1;
    check("async_rst_pc", bus.PC, 32'h0);
    check("async_rst_instr", bus.INSTRUCTION, BUBBLE);
    check("async_rst_ret", bus.RETIRED, 8'd0);
    check("async_rst_valid", bus.INSTR_VALID, 1'b0);
    check("async_rst_read", bus.IMEM_READ, 1'b1);
    tick();
    check("held_rst_pc", bus.PC, 32'h0);
    rst = 1'b0;
    bus.DATA_BUSYWAIT = 1'b0;
    model_pc = 32'h0;
    exp_ret  = 8'd0;
    run_instr(nop_to(32'h0000_0004));

    // PC wrap: jump back to 0xFFFF_FFFC, then sequential step wraps to 0.
    v = '{32'h00FE_0000, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0000};
    run_instr(v);
    v = '{32'h00FE_0000, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFC};
    run_instr(v);
    run_instr(nop_to(32'h0000_0000));

    // Retire counter wrap from all-ones back to zero.
    for (int g = 0; g < 300 && exp_ret != 8'hFF; g++) run_instr(nop_to(model_pc + 32'd4));
    check("ret_at_max", bus.RETIRED, 8'hFF);
    run_instr(nop_to(model_pc + 32'd4));
    check("ret_wrap", bus.RETIRED, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
